// File: rtl/processor_controller_if.sv
// Control bus between the processor controller and the datapath.
// Carries the instruction word into the controller and every datapath
// enable, select and address back out, plus the state codes for monitoring.
interface processor_controller_if;
  logic [15:0] IR;
  logic        PC_Clr;
  logic        PC_Up;
  logic        IR_Ld;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  State;
  logic [3:0]  NextState;

  // Controller side: consumes the instruction, drives the datapath controls.
  modport master (
    input  IR,
    output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, State, NextState
  );

  // Datapath / monitor side.
  modport slave (
    output IR,
    input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, State, NextState
  );
endinterface

// File: rtl/processor_controller.sv
// Moore control unit for the 16-bit processor. Sequences fetch, decode and
// execute; only the state is registered, every control output is decoded
// combinationally from the current state and the instruction register, so an
// asynchronous reset drops any active write enable immediately.
module processor_controller (
  input  logic                   Clk,
  input  logic                   Reset,
  processor_controller_if.master ctl
);

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    NOOP   = 4'd3,
    LOAD_A = 4'd4,
    LOAD_B = 4'd5,
    STORE  = 4'd6,
    ADD    = 4'd7,
    SUB    = 4'd8,
    HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  state_t     state;
  state_t     next_state;
  logic [3:0] opcode;

  assign opcode        = ctl.IR[15:12];
  assign ctl.State     = state;
  assign ctl.NextState = next_state;

  // State register; reset forces Init without waiting for a clock edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= INIT;
    else       state <= next_state;
  end

  // Next-state decode; unused opcodes fall through to Noop, illegal codes recover to Init.
  always_comb begin
    next_state = INIT;
    case (state)
      INIT:   next_state = FETCH;
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_STORE: next_state = STORE;
          OP_LOAD:  next_state = LOAD_A;
          OP_ADD:   next_state = ADD;
          OP_SUB:   next_state = SUB;
          OP_HALT:  next_state = HALT;
          default:  next_state = NOOP;
        endcase
      end
      LOAD_A: next_state = LOAD_B;
      LOAD_B: next_state = FETCH;
      NOOP:   next_state = FETCH;
      STORE:  next_state = FETCH;
      ADD:    next_state = FETCH;
      SUB:    next_state = FETCH;
      HALT:   next_state = HALT;
      default: next_state = INIT;
    endcase
  end

  // Per-state control outputs; everything defaults low so at most one write enable is ever active.
  always_comb begin
    ctl.PC_Clr     = 1'b0;
    ctl.PC_Up      = 1'b0;
    ctl.IR_Ld      = 1'b0;
    ctl.D_Addr     = 8'h00;
    ctl.D_Wr       = 1'b0;
    ctl.RF_s       = 1'b0;
    ctl.RF_W_addr  = 4'h0;
    ctl.RF_W_en    = 1'b0;
    ctl.RF_Ra_addr = 4'h0;
    ctl.RF_Rb_addr = 4'h0;
    ctl.ALU_s0     = ALU_PASS;
    case (state)
      INIT: ctl.PC_Clr = 1'b1;
      FETCH: begin
        ctl.IR_Ld = 1'b1;
        ctl.PC_Up = 1'b1;
      end
      // Synchronous data memory: present the address one cycle before write-back.
      LOAD_A: ctl.D_Addr = ctl.IR[11:4];
      LOAD_B: begin
        ctl.D_Addr    = ctl.IR[11:4];
        ctl.RF_s      = 1'b1;
        ctl.RF_W_addr = ctl.IR[3:0];
        ctl.RF_W_en   = 1'b1;
      end
      STORE: begin
        ctl.D_Addr     = ctl.IR[7:0];
        ctl.RF_Ra_addr = ctl.IR[11:8];
        ctl.D_Wr       = 1'b1;
      end
      ADD: begin
        ctl.RF_Ra_addr = ctl.IR[11:8];
        ctl.RF_Rb_addr = ctl.IR[7:4];
        ctl.RF_W_addr  = ctl.IR[3:0];
        ctl.RF_W_en    = 1'b1;
        ctl.ALU_s0     = ALU_ADD;
      end
      SUB: begin
        ctl.RF_Ra_addr = ctl.IR[11:8];
        ctl.RF_Rb_addr = ctl.IR[7:4];
        ctl.RF_W_addr  = ctl.IR[3:0];
        ctl.RF_W_en    = 1'b1;
        ctl.ALU_s0     = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/processor_controller.md
# processor_controller

Control unit for the 16-bit programmable processor. A Moore-style finite state machine that sequences the instruction program counter, instruction register, data memory, register file and ALU through fetch, decode and execute. It decodes the 16-bit instruction word held in the instruction register and drives every datapath enable, select and address. It sits inside `Processor` between the instruction register output and the datapath control inputs, and exports `State` and `NextState` for the testbench monitor.

## Interface
- No parameters. Widths are fixed by the 16-bit instruction set.
- `Clk` input 1: system clock; all state changes occur on the rising edge.
- `Reset` input 1: asynchronous, active-high; forces state to Init.
- `IR` input 16: current instruction register contents.
- `PC_Clr` output 1: clears the program counter.
- `PC_Up` output 1: increments the program counter.
- `IR_Ld` output 1: loads the instruction register from instruction memory.
- `D_Addr` output 8: data memory address.
- `D_Wr` output 1: data memory write enable.
- `RF_s` output 1: register-file write-data select; 1 = data memory, 0 = ALU.
- `RF_W_addr` output 4: register-file write address.
- `RF_W_en` output 1: register-file write enable.
- `RF_Ra_addr` output 4: register-file port A read address.
- `RF_Rb_addr` output 4: register-file port B read address.
- `ALU_s0` output 3: ALU function select; 000 = pass A, 001 = add, 010 = subtract.
- `State` output 4: current state code.
- `NextState` output 4: combinational next-state code.

## Operation
- Opcode is `IR[15:12]`. Instruction formats:
  - NOOP = 0000.
  - STORE = 0001: `IR[11:8]` = source register, `IR[7:0]` = address.
  - LOAD = 0010: `IR[11:4]` = address, `IR[3:0]` = destination register.
  - ADD = 0011 and SUB = 0100: `IR[11:8]` = Ra, `IR[7:4]` = Rb, `IR[3:0]` = Rd.
  - HALT = 0101.
  - Opcodes 0110–1111 execute as NOOP.
- State codes: Init=0, Fetch=1, Decode=2, Noop=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9.
  - Codes 10–15 are illegal; from any of them, NextState = Init.
- Transitions:
  - Init→Fetch.
  - Fetch→Decode.
  - Decode→{Noop, Store, LoadA, Add, Sub, Halt} according to opcode.
  - LoadA→LoadB→Fetch.
  - Noop, Store, Add and Sub each →Fetch.
  - Halt→Halt until `Reset` is asserted.
- Per-state outputs (every output not listed is 0):
  - Init: `PC_Clr`=1.
  - Fetch: `IR_Ld`=1, `PC_Up`=1.
  - Decode, Noop, Halt: all outputs 0.
  - LoadA: `D_Addr`=`IR[11:4]`.
  - LoadB: `D_Addr`=`IR[11:4]`, `RF_s`=1, `RF_W_addr`=`IR[3:0]`, `RF_W_en`=1.
  - Store: `D_Addr`=`IR[7:0]`, `RF_Ra_addr`=`IR[11:8]`, `D_Wr`=1.
  - Add: `RF_Ra_addr`=`IR[11:8]`, `RF_Rb_addr`=`IR[7:4]`, `RF_W_addr`=`IR[3:0]`, `RF_W_en`=1, `ALU_s0`=001.
  - Sub: same as Add, but `ALU_s0`=010.
- All outputs are purely combinational from `State` and `IR`. Only `State` is registered.

## Timing
- Reset asserted at any time, including mid-instruction: `State`=0 immediately, without waiting for a clock edge.
  - While in Init: `PC_Clr`=1, all other control outputs 0, `NextState`=1.
  - A write enable active in the aborted state drops in the same delta; no partial write may follow.
- First rising edge after `Reset` deasserts moves to Fetch.
- Cycle counts, Fetch through the return to Fetch:
  - NOOP, STORE, ADD, SUB: 3 cycles.
  - LOAD: 4 cycles, because the synchronous data memory needs one read cycle (LoadA) before write-back (LoadB).
- `IR` is stable from the edge that leaves Fetch until the next Fetch edge. The controller does not latch `IR`.
- `PC_Up` and `IR_Ld` are high for exactly one cycle per instruction.
- HALT: once State=9, the PC is frozen and no enables assert, indefinitely.
- Write-enable exclusivity: at most one of `D_Wr` and `RF_W_en` is high in any state; both are never 1 together.

## Test plan
- Reset and start:
  - Hold `Reset`=1 across 3 edges → `State`=0, `PC_Clr`=1 every cycle.
  - Release `Reset` → `State` sequence is 1, 2.
- LOAD: `IR`=16'h2A53 → Fetch, Decode, LoadA with `D_Addr`=8'hA5, then LoadB with `D_Addr`=8'hA5, `RF_s`=1, `RF_W_addr`=3, `RF_W_en`=1, then Fetch.
- ADD then SUB:
  - `IR`=16'h3127 → Add state with Ra=1, Rb=2, Rd=7, `ALU_s0`=001, `RF_W_en`=1.
  - `IR`=16'h4127 → Sub state with the same addresses and `ALU_s0`=010.
- STORE: `IR`=16'h1C0F → Store state with `RF_Ra_addr`=12, `D_Addr`=8'h0F, `D_Wr`=1, `RF_W_en`=0.
- HALT and illegal opcode:
  - `IR`=16'h5000 → State=9, held for 10 cycles with `PC_Up`=0 throughout.
  - `IR`=16'hF123 → Noop path, returns to Fetch in 3 cycles.
- Asynchronous reset mid-LOAD: assert `Reset` 2 ns after the edge into LoadB → `State`=0 and `RF_W_en`=0 before the next edge. After release, execution restarts at Fetch.
